// File: rtl/accumulate_3_1_obf.sv
// Locked burst accumulator fed by the calculate_3_0_obf product stream.
// Init value, burst length and idle polarity unlock only with the right key.
module accumulate_3_1_obf (
  input  logic         ap_clk,
  input  logic         ap_rst,
  input  logic         ap_start,
  output logic         ap_done,
  output logic         ap_idle,
  output logic         ap_ready,
  input  logic [31:0]  x,
  input  logic         x_ap_vld,
  output logic [31:0]  ap_return,
  input  logic [254:0] locking_key
);

  localparam logic [31:0] INIT_OBF = 32'hA5C31E97;
  localparam logic [3:0]  LEN_OBF  = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] ret_q, ret_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        done_q, done_d;

  logic [36:0] working_key;
  logic [31:0] const_init;
  logic [3:0]  const_len;
  logic [31:0] acc_sum;
  logic        unused_key;

  assign working_key = locking_key[36:0];
  assign unused_key  = ^locking_key[254:37];
  assign const_init  = INIT_OBF ^ working_key[31:0];
  assign const_len   = LEN_OBF ^ working_key[35:32];
  assign acc_sum     = acc_q + x;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ret_d   = ret_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ap_start) begin
          acc_d   = const_init;
          cnt_d   = {1'b0, const_len} + 5'd1;
          state_d = S_ACC;
        end
      end
      S_ACC: begin
        if (x_ap_vld) begin
          acc_d = acc_sum;
          cnt_d = cnt_q - 5'd1;
          // last sample is folded into the returned total
          if (cnt_q == 5'd1) begin
            ret_d   = acc_sum;
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ret_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ret_q   <= ret_d;
      done_q  <= done_d;
    end
  end

  assign ap_done   = done_q;
  assign ap_ready  = done_q;
  assign ap_return = ret_q;
  assign ap_idle   = (state_q == S_IDLE) ^ working_key[36];

endmodule

// File: tb/tb_accumulate_3_1_obf.sv
// Directed bench for accumulate_3_1_obf.
// Burst table plus reset-abort and back-to-back sequences.
module tb_accumulate_3_1_obf;

  logic         ap_clk;
  logic         ap_rst;
  logic         ap_start;
  logic         ap_done;
  logic         ap_idle;
  logic         ap_ready;
  logic [31:0]  x;
  logic         x_ap_vld;
  logic [31:0]  ap_return;
  logic [254:0] locking_key;

  int checks;
  int errors;

  localparam logic [36:0] KEY_OK = {1'b0, 4'h4, 32'hA5C31E97};

  accumulate_3_1_obf dut (
    .ap_clk     (ap_clk),
    .ap_rst     (ap_rst),
    .ap_start   (ap_start),
    .ap_done    (ap_done),
    .ap_idle    (ap_idle),
    .ap_ready   (ap_ready),
    .x          (x),
    .x_ap_vld   (x_ap_vld),
    .ap_return  (ap_return),
    .locking_key(locking_key)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  typedef struct {
    string       name;
    logic [36:0] key;
    logic [36:0] key_run;
    logic [31:0] xv;
    bit          alt;
    logic [31:0] exp_ret;
    int          exp_cyc;
    bit          exp_idle;
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic set_key(input logic [36:0] k);
    locking_key = {{218{1'b1}}, k};
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic run_burst(input vec_t v);
    int cyc;
    set_key(v.key);
    #1;
    chk({v.name, "_idle"}, 32'(ap_idle), 32'(v.exp_idle));
    ap_start = 1'b1;
    x_ap_vld = 1'b1;
    x        = 32'hDEAD_BEEF;
    step();
    cyc = 1;
    ap_start = 1'b0;
    set_key(v.key_run);
    while (!ap_done && cyc < 100) begin
      x_ap_vld = v.alt ? cyc[0] : 1'b1;
      x        = v.xv;
      step();
      cyc++;
    end
    x_ap_vld = 1'b0;
    chk({v.name, "_cyc"}, 32'(cyc), 32'(v.exp_cyc));
    chk({v.name, "_ret"}, ap_return, v.exp_ret);
    chk({v.name, "_rdy"}, 32'(ap_ready), 32'd1);
    step();
    chk({v.name, "_pulse"}, 32'(ap_done), 32'd0);
    chk({v.name, "_hold"}, ap_return, v.exp_ret);
  endtask

  initial begin
    vec_t v;
    int   cyc;
    int   ndone;
    int   last;
    bit   prev;
    bit   seen;

    checks   = 0;
    errors   = 0;
    ap_rst   = 1'b1;
    ap_start = 1'b0;
    x        = '0;
    x_ap_vld = 1'b0;
    set_key(KEY_OK);

    vecs[0] = '{"ones", KEY_OK, KEY_OK, 32'd1, 1'b0,
                32'd16, 17, 1'b1};
    vecs[1] = '{"wrap", KEY_OK, KEY_OK, 32'hFFFF_FFFF, 1'b0,
                32'hFFFF_FFF0, 17, 1'b1};
    vecs[2] = '{"gaps", KEY_OK, KEY_OK, 32'd3, 1'b1,
                32'd48, 32, 1'b1};
    vecs[3] = '{"badkey", 37'h10_0000_0000, 37'h10_0000_0000, 32'd1,
                1'b0, 32'hA5C3_1EA3, 13, 1'b0};
    vecs[4] = '{"len1", {1'b0, 4'hB, 32'hA5C31E97},
                {1'b0, 4'hB, 32'hA5C31E97}, 32'd7, 1'b0,
                32'd7, 2, 1'b1};
    vecs[5] = '{"keymid", KEY_OK, 37'h10_0000_0000, 32'd1, 1'b0,
                32'd16, 17, 1'b1};

    step();
    step();
    ap_rst = 1'b0;
    chk("rst_done", 32'(ap_done), 32'd0);
    chk("rst_ready", 32'(ap_ready), 32'd0);
    chk("rst_ret", ap_return, 32'd0);
    chk("rst_idle", 32'(ap_idle), 32'd1);

    for (int i = 0; i < 6; i++) begin
      run_burst(vecs[i]);
    end

    // abort a burst with reset after five samples
    set_key(KEY_OK);
    ap_start = 1'b1;
    step();
    ap_start = 1'b0;
    x        = 32'd2;
    x_ap_vld = 1'b1;
    seen     = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (ap_done) seen = 1'b1;
    end
    ap_rst = 1'b1;
    step();
    ap_rst   = 1'b0;
    x_ap_vld = 1'b0;
    if (ap_done) seen = 1'b1;
    chk("abort_nodone", 32'(seen), 32'd0);
    chk("abort_ret", ap_return, 32'd0);
    chk("abort_idle", 32'(ap_idle), 32'd1);
    v = '{"fresh", KEY_OK, KEY_OK, 32'd2, 1'b0, 32'd32, 17, 1'b1};
    run_burst(v);

    // start held high, valid held high: period 18, no stray sums
    ap_start = 1'b1;
    x_ap_vld = 1'b1;
    x        = 32'd1;
    ndone    = 0;
    last     = 0;
    prev     = 1'b0;
    for (cyc = 1; cyc <= 60; cyc++) begin
      step();
      if (ap_done) begin
        ndone++;
        chk("b2b_ret", ap_return, 32'd16);
        chk("b2b_cyc", 32'(cyc - last), (ndone == 1) ? 32'd17 : 32'd18);
        last = cyc;
        if (prev) chk("b2b_double", 32'd1, 32'd0);
      end
      prev = ap_done;
    end
    ap_start = 1'b0;
    x_ap_vld = 1'b0;
    chk("b2b_count", 32'(ndone), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
